// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-requester access sequencer for the single-ported dmem.
// Define DMEM_ARB_STATS_EN to add saturating grant and conflict counters.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]           grantCount0,
    output logic [15:0]           grantCount1,
    output logic [15:0]           conflictCount,
`endif
    output logic [ADDR_WIDTH-1:0] memReadAddress,
    output logic [ADDR_WIDTH-1:0] memWriteAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memReadWrite,
    input  logic [DATA_WIDTH-1:0] memReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_next;
    logic last_grant, cur_id, cur_we, win1, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign win1 = req1 & (~req0 | ~last_grant);
    assign sel_we = gnt1 ? we1 : we0;
    assign sel_addr = gnt1 ? addr1 : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;
    always_comb begin
        state_next = state;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        memReadWrite = 1'b0;
        case (state)
            IDLE: begin
                gnt0 = ~reset & req0 & ~win1;
                gnt1 = ~reset & win1;
                state_next = (req0 | req1) ? ACCESS : IDLE;
            end
            ACCESS: begin
                memReadWrite = ~reset & cur_we;
                state_next = cur_we ? IDLE : RESP;
            end
            RESP: begin
                rvalid0 = ~reset & ~cur_id;
                rvalid1 = ~reset & cur_id;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= 1'b1;
            cur_id <= 1'b0;
            cur_we <= 1'b0;
            memReadAddress <= '0;
            memWriteAddress <= '0;
            memWriteData <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            state <= state_next;
            if (gnt0 | gnt1) begin
                cur_id <= gnt1;
                cur_we <= sel_we;
                last_grant <= gnt1;
                if (sel_we) begin
                    memWriteAddress <= sel_addr;
                    memWriteData <= sel_wdata;
                end else begin
                    memReadAddress <= sel_addr;
                end
            end
            if (state == ACCESS && !cur_we && !cur_id) rdata0 <= memReadData;
            if (state == ACCESS && !cur_we && cur_id) rdata1 <= memReadData;
        end
    end
`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grantCount0 <= '0;
            grantCount1 <= '0;
            conflictCount <= '0;
        end else begin
            if (gnt0 && grantCount0 != 16'hFFFF) grantCount0 <= grantCount0 + 16'd1;
            if (gnt1 && grantCount1 != 16'hFFFF) grantCount1 <= grantCount1 + 16'd1;
            if (state == IDLE && req0 && req1 && conflictCount != 16'hFFFF)
                conflictCount <= conflictCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand-written round-robin and stats sequences.
module tb_dmem_arbiter;
    logic clk, reset;
    logic req0, we0, gnt0, rvalid0, req1, we1, gnt1, rvalid1, memReadWrite;
    logic [8:0] addr0, addr1, memReadAddress, memWriteAddress;
    logic [31:0] wdata0, wdata1, rdata0, rdata1, memWriteData, memReadData;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grantCount0, grantCount1, conflictCount;
`endif
    logic [31:0] mem [512] = '{default: '0};
    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef DMEM_ARB_STATS_EN
        .grantCount0(grantCount0), .grantCount1(grantCount1), .conflictCount(conflictCount),
`endif
        .memReadAddress(memReadAddress), .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData), .memReadWrite(memReadWrite), .memReadData(memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; addresses 30..49 are preloaded with address*10 for the round-robin reads.
    always @(posedge clk) if (memReadWrite) mem[memWriteAddress] <= memWriteData;
    assign memReadData = (memReadAddress >= 9'd30 && memReadAddress < 9'd50) ?
                         32'(memReadAddress) * 32'd10 : mem[memReadAddress];

    typedef struct {
        logic [31:0] rst, r0, w0, a0, d0, r1, w1, a1, d1;
        logic [31:0] g0, g1, v0, v1, rd0, rd1, rw, wa, wd, ra;
    } vec_t;
    vec_t tbl [24];
    vec_t v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic id;
    logic [31:0] exp_addr;
    int n0, n1;

    initial begin
        //          rst r0 w0 a0  d0     r1 w1 a1 d1   g0 g1 v0 v1 rd0 rd1    rw wa  wd     ra
        tbl[0]  = '{1,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 0,  0,     0};
        tbl[1]  = '{0,  1, 1, 10, 12345, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0,     0, 0,  0,     0};
        tbl[2]  = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     1, 10, 12345, 0};
        tbl[3]  = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 10, 12345, 0};
        tbl[4]  = '{0,  0, 0, 0,  0,     1, 0, 10, 0,  0, 1, 0, 0, 0,  0,     0, 10, 12345, 0};
        tbl[5]  = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 10, 12345, 10};
        tbl[6]  = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 1, 0,  12345, 0, 10, 12345, 10};
        tbl[7]  = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  12345, 0, 10, 12345, 10};
        tbl[8]  = '{1,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  12345, 0, 10, 12345, 10};
        tbl[9]  = '{0,  1, 1, 11, 6789,  1, 0, 11, 0,  1, 0, 0, 0, 0,  0,     0, 0,  0,     0};
        tbl[10] = '{0,  0, 0, 0,  0,     1, 0, 11, 0,  0, 0, 0, 0, 0,  0,     1, 11, 6789,  0};
        tbl[11] = '{0,  0, 0, 0,  0,     1, 0, 11, 0,  0, 1, 0, 0, 0,  0,     0, 11, 6789,  0};
        tbl[12] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 11, 6789,  11};
        tbl[13] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 1, 0,  6789,  0, 11, 6789,  11};
        tbl[14] = '{0,  1, 1, 20, 555,   0, 0, 0, 0,   1, 0, 0, 0, 0,  6789,  0, 11, 6789,  11};
        tbl[15] = '{1,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  6789,  0, 20, 555,   11};
        tbl[16] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 0,  0,     0};
        tbl[17] = '{0,  1, 0, 20, 0,     0, 0, 0, 0,   1, 0, 0, 0, 0,  0,     0, 0,  0,     0};
        tbl[18] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 0,  0,     20};
        tbl[19] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 1, 0, 0,  0,     0, 0,  0,     20};
        tbl[20] = '{0,  0, 0, 0,  0,     1, 0, 10, 0,  0, 1, 0, 0, 0,  0,     0, 0,  0,     20};
        tbl[21] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 0,  0,     10};
        tbl[22] = '{1,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  12345, 0, 0,  0,     10};
        tbl[23] = '{0,  0, 0, 0,  0,     0, 0, 0, 0,   0, 0, 0, 0, 0,  0,     0, 0,  0,     0};
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            v = tbl[i];
            @(negedge clk);
            reset = v.rst[0];
            req0 = v.r0[0]; we0 = v.w0[0]; addr0 = v.a0[8:0]; wdata0 = v.d0;
            req1 = v.r1[0]; we1 = v.w1[0]; addr1 = v.a1[8:0]; wdata1 = v.d1;
            #1;
            n_vec++;
            if (gnt0 !== v.g0[0] || gnt1 !== v.g1[0] || rvalid0 !== v.v0[0] ||
                rvalid1 !== v.v1[0] || rdata0 !== v.rd0 || rdata1 !== v.rd1 ||
                memReadWrite !== v.rw[0] || 32'(memWriteAddress) !== v.wa ||
                memWriteData !== v.wd || 32'(memReadAddress) !== v.ra) begin
                n_err++;
                $display("FAIL vec%0d: got g=%b%b v=%b%b rd0=%0d rd1=%0d rw=%b wa=%0d wd=%0d ra=%0d; expected g=%b%b v=%b%b rd0=%0d rd1=%0d rw=%b wa=%0d wd=%0d ra=%0d",
                    i, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, memReadWrite,
                    memWriteAddress, memWriteData, memReadAddress,
                    v.g0[0], v.g1[0], v.v0[0], v.v1[0], v.rd0, v.rd1, v.rw[0], v.wa, v.wd, v.ra);
            end
        end
        // Both requesters hold requests for four reads each: grants must alternate 0,1,0,1...
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            id = (k % 2) == 1;
            @(negedge clk);
            req0 = n0 < 4; addr0 = 9'(30 + n0);
            req1 = n1 < 4; addr1 = 9'(40 + n1);
            #1;
            chk("rr_gnt0", 32'(gnt0), 32'(!id));
            chk("rr_gnt1", 32'(gnt1), 32'(id));
            exp_addr = id ? 32'(40 + n1) : 32'(30 + n0);
            if (id) n1++; else n0++;
            @(negedge clk);
            req0 = n0 < 4; addr0 = 9'(30 + n0);
            req1 = n1 < 4; addr1 = 9'(40 + n1);
            #1;
            chk("rr_busy_gnt", 32'(gnt0 | gnt1), 32'd0);
            chk("rr_raddr", 32'(memReadAddress), exp_addr);
            chk("rr_rw", 32'(memReadWrite), 32'd0);
            @(negedge clk);
            #1;
            chk("rr_rvalid0", 32'(rvalid0), 32'(!id));
            chk("rr_rvalid1", 32'(rvalid1), 32'(id));
            chk("rr_rdata", id ? rdata1 : rdata0, exp_addr * 32'd10);
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        #1;
        chk("stats_gc0", 32'(grantCount0), 32'd4);
        chk("stats_gc1", 32'(grantCount1), 32'd4);
        chk("stats_conflict", 32'(conflictCount), 32'd7);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_rdata0", rdata0, 32'd0);
        chk("post_reset_rdata1", rdata1, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("reset_gc0", 32'(grantCount0), 32'd0);
        chk("reset_gc1", 32'(grantCount1), 32'd0);
        chk("reset_conflict", 32'(conflictCount), 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
